iir_selftrig_arbiter: RTL

IIR_SELFTRIG_ARBITER -- requirements
Module: iir_selftrig_arbiter

---
 rtl/iir_selftrig_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/iir_selftrig_arbiter.sv
// ---------------------------------------------------------------------------
// iir_selftrig_arbiter
// Collects per-channel self-trigger edges, timestamps them, applies a
// per-channel holdoff, and hands one record at a time to a valid/ready sink
// using round-robin arbitration between pending channels.
//
// Parameters
//   NCH      number of self-trigger channels (2..8)
//   HOLDOFF  cycles a channel ignores new edges after an accepted edge (1..4095)
//
// Ports
//   clk            single clock, all logic on posedge
//   reset          synchronous, active-high reset
//   enable         global acquisition enable (gates timestamp and new edges)
//   ch_enable      per-channel trigger mask
//   trigger        per-channel trigger level
//   rec_valid      record available
//   rec_ready      downstream accepts the record
//   rec_channel    granted channel index
//   rec_timestamp  timestamp latched at the accepted edge
//   pending        per-channel pending flags
//   drop_count     (only with SELFTRIG_DROP_COUNT_EN) saturating count of edges
//                  dropped because the channel already had a pending record
//
// Optional feature macro: SELFTRIG_DROP_COUNT_EN
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no record presented; grant the next pending channel if any
// S_SEND | record presented on rec_*, waiting for rec_ready
// ---------------------------------------------------------------------------
module iir_selftrig_arbiter #(
    parameter int NCH     = 4,
    parameter int HOLDOFF = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [NCH-1:0] ch_enable,
    input  logic [NCH-1:0] trigger,
    output logic           rec_valid,
    input  logic           rec_ready,
    output logic [2:0]     rec_channel,
    output logic [31:0]    rec_timestamp,
    output logic [NCH-1:0] pending
`ifdef SELFTRIG_DROP_COUNT_EN
    ,
    output logic [15:0]    drop_count
`endif
);

    localparam int HW = 12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [31:0]    r_cnt;
    logic [NCH-1:0] r_trig_d;
    logic [NCH-1:0] r_pend;
    logic [HW-1:0]  r_hold [NCH];
    logic [31:0]    r_ts   [NCH];
    logic [2:0]     r_last;
    logic           r_valid;
    logic [2:0]     r_chan;
    logic [31:0]    r_rts;

    logic [NCH-1:0] w_edge;
    logic [NCH-1:0] w_free;
    logic [NCH-1:0] w_elig;
    logic [NCH-1:0] w_accept;
    logic [NCH-1:0] w_clr;
    logic           w_found;
    logic           w_grant;
    logic [2:0]     w_gnt_idx;

    assign w_edge   = trigger & ~r_trig_d;
    assign w_elig   = w_edge & ch_enable & w_free & {NCH{enable}};
    assign w_accept = w_elig & ~r_pend;

    always_comb begin
        w_free = '0;
        for (int i = 0; i < NCH; i++) begin
            w_free[i] = (r_hold[i] == '0);
        end
    end

    // Scan from farthest to nearest offset so the channel right after the
    // last grant ends up winning.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (r_pend[(int'(r_last) + k) % NCH]) begin
                w_found   = 1'b1;
                w_gnt_idx = 3'((int'(r_last) + k) % NCH);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (rec_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_trig_d <= '0;
            r_pend   <= '0;
            r_last   <= 3'(NCH - 1);
            r_valid  <= 1'b0;
            r_chan   <= '0;
            r_rts    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
                r_ts[i]   <= '0;
            end
        end else begin
            r_trig_d <= trigger;
            if (enable) begin
                r_cnt <= r_cnt + 32'd1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_accept[i]) begin
                    r_hold[i] <= HW'(HOLDOFF);
                    r_ts[i]   <= r_cnt;
                end else if (r_hold[i] != '0) begin
                    r_hold[i] <= r_hold[i] - HW'(1);
                end
            end
            // Set wins over clear; in practice they never hit the same bit.
            r_pend <= (r_pend & ~w_clr) | w_accept;
            if (w_grant) begin
                r_valid <= 1'b1;
                r_chan  <= w_gnt_idx;
                r_rts   <= r_ts[w_gnt_idx];
                r_last  <= w_gnt_idx;
            end else if (r_state == S_SEND && rec_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SELFTRIG_DROP_COUNT_EN
    logic [NCH-1:0] w_drop;
    logic [15:0]    r_drop;
    logic [16:0]    w_drop_sum;

    assign w_drop     = w_elig & r_pend;
    assign w_drop_sum = {1'b0, r_drop} + 17'($countones(w_drop));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_drop_sum[16]) begin
            r_drop <= 16'hFFFF;
        end else begin
            r_drop <= w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop;
`endif

    assign rec_valid     = r_valid;
    assign rec_channel   = r_chan;
    assign rec_timestamp = r_rts;
    assign pending       = r_pend;

endmodule
